// File: rtl/fft_result_unload.sv
// Streams a finished FFT out of the working memory in natural order, hiding the
// memory read latency behind a small credit-controlled FIFO.
module fft_result_unload #(
    parameter int N_LOG2   = 5,
    parameter int WIDTH    = 16,
    parameter int READ_LAT = 3,
    parameter int BITREV   = 0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              result_bank,
    output logic [N_LOG2-1:0] read_G_addr,
    output logic              bank_read_sel,
    output logic              rw_addr_en,
    input  logic [WIDTH-1:0]  G_real,
    input  logic [WIDTH-1:0]  G_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_real,
    output logic [WIDTH-1:0]  out_imag,
    output logic [N_LOG2-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int D  = READ_LAT + 1;
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);
    localparam logic [N_LOG2-1:0] K_LAST = '1;
    localparam logic [PW-1:0]     P_LAST = PW'(D - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          state;
    logic [N_LOG2-1:0]   k;
    logic [N_LOG2-1:0]   k_rev;
    logic [READ_LAT-1:0] vld_pipe;
    logic [N_LOG2-1:0]   idx_pipe [READ_LAT];
    logic [WIDTH-1:0]    fifo_re  [D];
    logic [WIDTH-1:0]    fifo_im  [D];
    logic [N_LOG2-1:0]   fifo_idx [D];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       inflight;
    logic [CW:0]         occupancy;
    logic                issue, push, pop;

    always_comb begin
        k_rev = '0;
        for (int i = 0; i < N_LOG2; i++) k_rev[i] = k[N_LOG2-1-i];
    end

    assign read_G_addr = (BITREV != 0) ? k_rev : k;
    assign rw_addr_en  = 1'b0;
    assign busy        = (state != S_IDLE);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    // A read is only issued if its data is guaranteed a FIFO slot on arrival.
    assign occupancy = (CW+1)'(inflight) + (CW+1)'(fifo_count) - (CW+1)'(pop);
    assign issue     = (state == S_ISSUE) && (occupancy < (CW+1)'(D));
    assign push      = vld_pipe[READ_LAT-1];
    assign pop       = out_valid && out_ready;

    assign out_valid = (fifo_count != '0);
    assign out_real  = out_valid ? fifo_re[rd_ptr]  : '0;
    assign out_imag  = out_valid ? fifo_im[rd_ptr]  : '0;
    assign out_index = out_valid ? fifo_idx[rd_ptr] : '0;
    assign out_last  = out_valid && (fifo_idx[rd_ptr] == K_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            state         <= S_IDLE;
            k             <= '0;
            bank_read_sel <= 1'b0;
            vld_pipe      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            done          <= 1'b0;
        end else begin
            done       <= 1'b0;
            vld_pipe   <= (vld_pipe << 1) | READ_LAT'(issue);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= (wr_ptr == P_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == P_LAST) ? '0 : rd_ptr + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    state         <= S_ISSUE;
                    k             <= '0;
                    bank_read_sel <= result_bank;
                end
                S_ISSUE: if (issue) begin
                    if (k == K_LAST) state <= S_DRAIN;
                    else             k     <= k + 1'b1;
                end
                S_DRAIN: if (pop && out_last) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath storage needs no reset: validity lives in vld_pipe and fifo_count.
    always_ff @(posedge clk) begin
        idx_pipe[0] <= k;
        for (int i = 1; i < READ_LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
        if (push) begin
            fifo_re[wr_ptr]  <= G_real;
            fifo_im[wr_ptr]  <= G_imag;
            fifo_idx[wr_ptr] <= idx_pipe[READ_LAT-1];
        end
    end
endmodule

// File: tb/tb_fft_result_unload.sv
// Directed bench: natural and bit-reversed instances share stimulus, each fed by
// a 3-stage registered memory model returning real=addr(+64 on bank 0), imag=-addr.
module tb_fft_result_unload;
    logic clk = 1'b0;
    logic clear, start, result_bank, out_ready;
    always #5 clk = ~clk;

    logic [4:0]  a0, a1, ox0, ox1;
    logic        bs0, bs1, rw0, rw1, ov0, ov1, ol0, ol1, by0, by1, dn0, dn1;
    logic [15:0] gr0, gi0, gr1, gi1, or0, oi0, or1, oi1;

    int tests = 0;
    int fails = 0;

    fft_result_unload #(.N_LOG2(5), .WIDTH(16), .READ_LAT(3), .BITREV(0)) dut0 (
        .clk(clk), .clear(clear), .start(start), .result_bank(result_bank),
        .read_G_addr(a0), .bank_read_sel(bs0), .rw_addr_en(rw0),
        .G_real(gr0), .G_imag(gi0), .out_valid(ov0), .out_ready(out_ready),
        .out_real(or0), .out_imag(oi0), .out_index(ox0), .out_last(ol0),
        .busy(by0), .done(dn0));

    fft_result_unload #(.N_LOG2(5), .WIDTH(16), .READ_LAT(3), .BITREV(1)) dut1 (
        .clk(clk), .clear(clear), .start(start), .result_bank(result_bank),
        .read_G_addr(a1), .bank_read_sel(bs1), .rw_addr_en(rw1),
        .G_real(gr1), .G_imag(gi1), .out_valid(ov1), .out_ready(out_ready),
        .out_real(or1), .out_imag(oi1), .out_index(ox1), .out_last(ol1),
        .busy(by1), .done(dn1));

    logic [4:0]  m0a, m1a;
    logic        m0b, m1b;
    logic [15:0] m0r, m0i, m1r, m1i;
    always_ff @(posedge clk) begin
        m0a <= a0;  m0b <= bs0;
        m1a <= a1;  m1b <= bs1;
        m0r <= {11'd0, m0a} + (m0b ? 16'd0 : 16'd64);
        m0i <= 16'd0 - {11'd0, m0a};
        m1r <= {11'd0, m1a} + (m1b ? 16'd0 : 16'd64);
        m1i <= 16'd0 - {11'd0, m1a};
        gr0 <= m0r;  gi0 <= m0i;
        gr1 <= m1r;  gi1 <= m1i;
    end

    function automatic logic [4:0] br5(input logic [4:0] x);
        for (int i = 0; i < 5; i++) br5[i] = x[4-i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_addr"}, 32'(a0), 0);
        chk({tag, "_bank"}, 32'(bs0), 0);
        chk({tag, "_rw"}, 32'(rw0), 0);
        chk({tag, "_valid"}, 32'(ov0), 0);
        chk({tag, "_data"}, {or0, oi0}, 0);
        chk({tag, "_idx_last"}, {26'd0, ox0, ol0}, 0);
        chk({tag, "_busy_done"}, {30'd0, by0, dn0}, 0);
    endtask

    // mode 0: ready high, 1: patterned stalls, 2: ready low for cycles 0..19
    task automatic run(input logic bank, input int mode, input int restart_at, input int clear_at);
        int n, dones, first_hs, last_hs, done_cyc, nprev;
        logic [4:0]  kprev, px;
        logic [15:0] pr, pi, er, ei, er1;
        logic stall, fin;
        n = 0; dones = 0; first_hs = -1; last_hs = -1; done_cyc = -1;
        nprev = 0; kprev = '0; stall = 1'b0; fin = 1'b0;
        pr = '0; pi = '0; px = '0;
        start = 1'b1;
        result_bank = bank;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) start = (cyc == restart_at);
            clear = (cyc == clear_at);
            case (mode)
                1:       out_ready = ((cyc * 5) % 11) < 4;
                2:       out_ready = (cyc >= 20);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (cyc == 1) begin
                chk("busy_c1", 32'(by0), 1);
                chk("bank_sel", 32'(bs0), 32'(bank));
            end
            if (mode != 2 && cyc >= 1 && cyc <= 4) begin
                chk("addr_nat", 32'(a0), 32'(cyc - 1));
                chk("addr_rev", 32'(a1), 32'(br5(5'(cyc - 1))));
            end
            if (mode == 2 && cyc == 19) begin
                chk("stall_addr", 32'(a0), 4);
                chk("stall_head", {26'd0, ox0, ov0}, 1);
            end
            if (stall) chk("stable", {or0, oi0}, {pr, pi});
            if (stall) chk("stable_idx", {26'd0, px, ov0}, {26'd0, px, 1'b1});
            if (clear_at < 0 && cyc > 1 && a0 != kprev)
                chk("credit", 32'((int'(kprev) - nprev) < 4), 1);
            if (clear_at >= 0 && cyc == clear_at + 1) reset_chk("clear");
            if (clear_at >= 0 && cyc > clear_at + 1) chk("no_stale", {31'd0, ov0}, 0);
            if (clear_at >= 0 && cyc == clear_at + 6) fin = 1'b1;
            if (ov0 && out_ready) begin
                er  = 16'(n) + (bank ? 16'd0 : 16'd64);
                ei  = 16'd0 - 16'(n);
                er1 = {11'd0, br5(5'(n))} + (bank ? 16'd0 : 16'd64);
                chk("index", 32'(ox0), 32'(n));
                chk("data", {or0, oi0}, {er, ei});
                chk("last", 32'(ol0), 32'(n == 31));
                if (mode == 0 && clear_at < 0) begin
                    chk("rev_idx_valid", {26'd0, ox1, ov1}, {26'd0, 5'(n), 1'b1});
                    chk("rev_data", {or1, oi1}, {er1, 16'd0 - {11'd0, br5(5'(n))}});
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                n++;
            end
            if (dn0) begin
                dones++;
                done_cyc = cyc;
                chk("busy_at_done", 32'(by0), 0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) fin = 1'b1;
            stall = ov0 && !out_ready;
            pr = or0; pi = oi0; px = ox0;
            kprev = a0;
            nprev = n;
            @(posedge clk);
            #1;
            if (fin) break;
        end
        start = 1'b0;
        clear = 1'b0;
        if (clear_at < 0) begin
            chk("sample_count", 32'(n), 32);
            chk("done_count", 32'(dones), 1);
            if (mode == 0) begin
                chk("first_cycle", 32'(first_hs), 5);
                chk("last_cycle", 32'(last_hs), 36);
                chk("done_cycle", 32'(done_cyc), 37);
            end
        end
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; result_bank = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_chk("reset");
        @(posedge clk);
        #1;
        clear = 1'b0;
        run(1'b1, 0, -1, -1);
        run(1'b0, 1, -1, -1);
        run(1'b1, 0, 10, -1);
        run(1'b1, 0, -1, 12);
        run(1'b1, 0, -1, -1);
        run(1'b1, 2, -1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_result_unload.md
# fft_result_unload

Streams the 2^N_LOG2 complex results of a completed FFT out of the dual-bank working memory, one sample per handshake, in natural frequency order. Sits between the FFT controller and the downstream consumer: it drives the memory G-port read address and bank select, absorbs the memory's fixed read latency in a small credit-controlled FIFO, and presents a valid/ready stream. It is the read-out counterpart of the memory's load-data write path.

## Interface
- N_LOG2, 5, log2 of transform length (32 points).
- WIDTH, 16, bits per real/imag component.
- READ_LAT, 3, cycles from read_G_addr/bank_read_sel change to matching data on G_real/G_imag (address mux, RAM, output mux all registered).
- BITREV, 0, 1 = results stored bit-reversed; address issued is bit-reverse of sample index.
- clk  in  1  clock; all logic on rising edge.
- clear  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse: begin unloading; ignored while busy.
- result_bank  in  1  bank holding final results; sampled on accepted start.
- read_G_addr  out  N_LOG2  memory G-port read address.
- bank_read_sel  out  1  memory bank select for read.
- rw_addr_en  out  1  memory read/write address select; held 0 (read).
- G_real, G_imag  in  WIDTH  memory read data.
- out_valid  out  1  out_* hold a sample.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_real, out_imag  out  WIDTH  sample data.
- out_index  out  N_LOG2  natural-order sample index k.
- out_last  out  1  high with sample k = 2^N_LOG2-1.
- busy  out  1  high from accepted start through last handshake.
- done  out  1  one-cycle pulse after last handshake.

## Operation
- FSM: IDLE -> ISSUE on start (clear=0, state IDLE); ISSUE -> DRAIN after issuing index 2^N_LOG2-1; DRAIN -> IDLE on handshake of out_last, with done pulsed the following cycle.
- Issue counter k: read_G_addr = k (BITREV=0) or bitrev(k) (BITREV=1); increments by 1 per issue, no wrap within a run.
- In-flight tracking: READ_LAT-deep valid shift register carrying (k); entry at tail writes {G_real, G_imag, k} into FIFO.
- FIFO depth D = READ_LAT+1; out_* driven from FIFO head; out_valid = FIFO non-empty; pop on handshake.
- Credit rule: issue in a cycle only if inflight + fifo_count - pop < D. FIFO never overflows; ready held high gives 1 sample/cycle.
- out_* stable while out_valid & !out_ready.
- start while busy: ignored, no effect on k, bank, or stream.
- result_bank latched at accepted start; bank_read_sel holds it until next accepted start.
- Reset (including mid-run): state IDLE, k=0, shift register and FIFO flushed, in-flight data discarded.

## Timing
- Reset values: read_G_addr 0, bank_read_sel 0, rw_addr_en 0, out_valid 0, out_real/imag 0, out_index 0, out_last 0, busy 0, done 0.
- start high in cycle 0 -> busy and first address (k=0) in cycle 1.
- Address issued in cycle t -> data captured end of cycle t+READ_LAT -> out_valid in cycle t+READ_LAT+1 (cycle 5 for default).
- out_ready held high: samples k=0..31 in cycles 5..36, out_last in 36, busy low and done high in cycle 37.
- out_ready low: issue stops once D entries outstanding; resumes the cycle a pop frees a slot; no sample lost or duplicated.
- New start accepted in the cycle done is high.

## Test plan
- Memory model with READ_LAT=3, word k = {real=k, imag=-k}; start, result_bank=1, ready high -> bank_read_sel=1, samples 0..31 in cycles 5..36 in order, out_last only at 31, done at cycle 37.
- Same, out_ready toggled pseudo-randomly -> identical ordered 32-sample sequence, out_* stable while stalled, FIFO never holds >4, read_G_addr never advances while 4 outstanding.
- BITREV=1 -> addresses 0,16,8,24,...; out_index still 0..31 natural, data = word at bitrev(k).
- Second start pulse at cycle 10 of a run -> ignored; exactly 32 samples, single done.
- clear asserted at cycle 12 mid-run with 3 reads in flight -> next cycle all outputs at reset values, no stale sample emitted; fresh start then yields full correct 32-sample stream.
- out_ready low from cycle 0 for 20 cycles -> exactly 4 addresses issued, out_valid high with sample 0 held until ready rises.
